fifo_mem_ctrl: RTL and testbench

- Initiator-side controller for the dual-port 8x4 memory (memoria); the memory is the responder.
- Presents a FIFO push/pop interface to upstream and downstream logic.
- Drives memory port A for writes only and port B for reads only.
- Tracks occupancy and full/empty status, and reports overflow and underflow errors.

---
 rtl/fifo_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fifo_mem_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mem_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_mem_ctrl
//
// Initiator-side controller that turns a dual-port 8x4 memory (the responder)
// into a FIFO. Port A of the memory is used only for writes and port B only
// for reads. Occupancy is tracked in a count register and every status flag
// is decoded from it. Overflow and underflow set a sticky error flag that
// only reset clears.
//
// Optional feature macro: FIFO_MEM_CTRL_ALMOST_EN
//   defined   : almost_full  = (count >= ALMOST_FULL_LVL)
//               almost_empty = (count <= ALMOST_EMPTY_LVL)
//   undefined : both outputs tied 0 and no comparators are built.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   push         in   write request this cycle
//   data_in      in   entry to write
//   pop          in   read request this cycle
//   data_out     out  popped entry, combinational pass-through of DataOutB
//   valid_out    out  data_out holds a popped entry this cycle
//   full         out  count == depth
//   empty        out  count == 0
//   almost_full  out  see macro above
//   almost_empty out  see macro above
//   error        out  sticky overflow/underflow flag
//   count        out  current occupancy, 0..depth
//   AddrA        out  memory port A address (write pointer)
//   rwA          out  memory port A write enable (1 = write)
//   DataInA      out  memory port A write data
//   AddrB        out  memory port B address (read pointer)
//   rwB          out  memory port B direction, tied to read
//   DataInB      out  memory port B write data, tied 0
//   DataOutB     in   memory port B read data, one cycle after AddrB sampled
// -----------------------------------------------------------------------------
module fifo_mem_ctrl #(
    parameter int DATA_WIDTH       = 4,
    parameter int ADDR_WIDTH       = 3,
    parameter int ALMOST_FULL_LVL  = 6,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] AddrA,
    output logic                  rwA,
    output logic [DATA_WIDTH-1:0] DataInA,
    output logic [ADDR_WIDTH-1:0] AddrB,
    output logic                  rwB,
    output logic [DATA_WIDTH-1:0] DataInB,
    input  logic [DATA_WIDTH-1:0] DataOutB
);

    // Count value meaning "every slot occupied": a one in the MSB only.
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  valid_q,  valid_d;
    logic                  error_q,  error_d;

    logic push_ok;
    logic pop_ok;

    // ------------------------------------------------------------------
    // Status decode
    // ------------------------------------------------------------------
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

`ifdef FIFO_MEM_CTRL_ALMOST_EN
    assign almost_full  = (count_q >= (ADDR_WIDTH+1)'(ALMOST_FULL_LVL));
    assign almost_empty = (count_q <= (ADDR_WIDTH+1)'(ALMOST_EMPTY_LVL));
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Accept rules. A push into a full FIFO is still accepted when a pop
    // frees a slot on the same edge. The reverse is not true: popping an
    // empty FIFO is refused even with a concurrent push, since the memory
    // cannot forward the write data to the read port in the same cycle.
    // ------------------------------------------------------------------
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // ------------------------------------------------------------------
    // Memory interface. The write strobe is masked during reset so that a
    // push asserted alongside reset never corrupts the array.
    // ------------------------------------------------------------------
    assign AddrA   = wr_ptr_q;
    assign rwA     = push_ok & ~reset;
    assign DataInA = data_in;

    assign AddrB   = rd_ptr_q;
    assign rwB     = 1'b0;
    assign DataInB = '0;

    assign data_out  = DataOutB;
    assign valid_out = valid_q;
    assign error     = error_q;
    assign count     = count_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers wrap naturally because they are exactly ADDR_WIDTH wide.
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // The memory returns the entry at the old rd_ptr one cycle later,
        // so the valid strobe is simply the registered pop acceptance.
        valid_d = pop_ok;

        // Dropped push (overflow) or refused pop (underflow) latch the flag.
        error_d = error_q | (push & ~push_ok) | (pop & empty);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_mem_ctrl
//
// Directed bench for fifo_mem_ctrl. A behavioural model of the dual-port
// 8x4 memory sits on the controller's memory ports: port A writes on the
// rising edge when rwA=1, port B registers mem[AddrB] on every rising edge
// (read-before-write when both ports hit the same address).
// Inputs change 1 ns after the rising edge; outputs are sampled after that.
// -----------------------------------------------------------------------------
module tb_fifo_mem_ctrl;

    localparam int DW = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;
    logic [AW:0]   count;
    logic [AW-1:0] AddrA;
    logic          rwA;
    logic [DW-1:0] DataInA;
    logic [AW-1:0] AddrB;
    logic          rwB;
    logic [DW-1:0] DataInB;
    logic [DW-1:0] DataOutB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_mem_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .count        (count),
        .AddrA        (AddrA),
        .rwA          (rwA),
        .DataInA      (DataInA),
        .AddrB        (AddrB),
        .rwB          (rwB),
        .DataInB      (DataInB),
        .DataOutB     (DataOutB)
    );

    // Memory model (responder)
    logic [DW-1:0] mem [8];
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        DataOutB = '0;
    end
    always @(posedge clk) begin
        if (rwA) mem[AddrA] <= DataInA;
        DataOutB <= mem[AddrB];
    end

    function automatic logic exp_af(int c);
`ifdef FIFO_MEM_CTRL_ALMOST_EN
        return (c >= 6);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_ae(int c);
`ifdef FIFO_MEM_CTRL_ALMOST_EN
        return (c <= 2);
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic p, input logic [DW-1:0] d, input logic q);
        push    = p;
        data_in = d;
        pop     = q;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1'b0, '0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    // Push n consecutive values starting at first; wr_ptr starts at addr0.
    task automatic push_seq(input logic [DW-1:0] first, input int n,
                            input int addr0, input int cnt0);
        for (int i = 0; i < n; i++) begin
            set_in(1'b1, first + DW'(i), 1'b0);
            checks++;
            if (AddrA !== AW'((addr0 + i) % 8) || rwA !== 1'b1) begin
                errors++;
                $display("FAIL push_addr[%0d]: AddrA=%0d rwA=%b, expected AddrA=%0d rwA=1",
                         i, AddrA, rwA, (addr0 + i) % 8);
            end
            tick();
            checks++;
            if (count !== (AW+1)'(cnt0 + i + 1) || almost_full !== exp_af(cnt0 + i + 1)
                || almost_empty !== exp_ae(cnt0 + i + 1)) begin
                errors++;
                $display("FAIL push_count[%0d]: count=%0d af=%b ae=%b, expected count=%0d af=%b ae=%b",
                         i, count, almost_full, almost_empty, cnt0 + i + 1,
                         exp_af(cnt0 + i + 1), exp_ae(cnt0 + i + 1));
            end
        end
        set_in(1'b0, '0, 1'b0);
    endtask

    // Pop n entries and expect consecutive values starting at first.
    task automatic pop_seq(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, '0, 1'b1);
            tick();
            checks++;
            if (valid_out !== 1'b1 || data_out !== first + DW'(i)) begin
                errors++;
                $display("FAIL pop_data[%0d]: valid_out=%b data_out=%h, expected valid_out=1 data_out=%h",
                         i, valid_out, data_out, first + DW'(i));
            end
        end
        set_in(1'b0, '0, 1'b0);
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL pop_valid_drop: valid_out=%b, expected 0", valid_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b1, 4'h5, 1'b0);
        checks++;
        if (rwA !== 1'b0) begin
            errors++;
            $display("FAIL reset_rwA_masked: rwA=%b, expected 0", rwA);
        end
        tick();
        reset = 1'b0;
        set_in(1'b0, '0, 1'b0);
        repeat (3) tick();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== '0 || error !== 1'b0
            || rwA !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: empty=%b full=%b count=%0d error=%b rwA=%b valid_out=%b, expected 1 0 0 0 0 0",
                     empty, full, count, error, rwA, valid_out);
        end
        checks++;
        if (almost_full !== exp_af(0) || almost_empty !== exp_ae(0)
            || rwB !== 1'b0 || DataInB !== '0 || AddrA !== '0 || AddrB !== '0) begin
            errors++;
            $display("FAIL reset_aux: af=%b ae=%b rwB=%b DataInB=%h AddrA=%0d AddrB=%0d, expected af=%b ae=%b 0 0 0 0",
                     almost_full, almost_empty, rwB, DataInB, AddrA, AddrB, exp_af(0), exp_ae(0));
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        push_seq(4'h1, 8, 0, 0);
        checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b empty=%b, expected full=1 empty=0", full, empty);
        end
        pop_seq(4'h1, 8);
        checks++;
        if (empty !== 1'b1 || count !== '0 || error !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: empty=%b count=%0d error=%b, expected 1 0 0", empty, count, error);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        push_seq(4'h1, 8, 0, 0);
        set_in(1'b1, 4'hF, 1'b0);
        checks++;
        if (rwA !== 1'b0) begin
            errors++;
            $display("FAIL overflow_rwA: rwA=%b, expected 0", rwA);
        end
        tick();
        set_in(1'b0, '0, 1'b0);
        checks++;
        if (count !== 4'd8 || error !== 1'b1 || AddrA !== 3'd0) begin
            errors++;
            $display("FAIL overflow_state: count=%0d error=%b AddrA=%0d, expected 8 1 0", count, error, AddrA);
        end
        pop_seq(4'h1, 8);
    endtask

    task automatic test_underflow();
        do_reset();
        set_in(1'b0, '0, 1'b1);
        tick();
        checks++;
        if (valid_out !== 1'b0 || error !== 1'b1 || AddrB !== 3'd0 || count !== '0) begin
            errors++;
            $display("FAIL underflow: valid_out=%b error=%b AddrB=%0d count=%0d, expected 0 1 0 0",
                     valid_out, error, AddrB, count);
        end
        // Push and pop while empty: push wins, pop refused.
        set_in(1'b1, 4'h3, 1'b1);
        checks++;
        if (rwA !== 1'b1) begin
            errors++;
            $display("FAIL empty_pushpop_rwA: rwA=%b, expected 1", rwA);
        end
        tick();
        set_in(1'b0, '0, 1'b0);
        checks++;
        if (count !== 4'd1 || valid_out !== 1'b0 || error !== 1'b1 || AddrB !== 3'd0) begin
            errors++;
            $display("FAIL empty_pushpop: count=%0d valid_out=%b error=%b AddrB=%0d, expected 1 0 1 0",
                     count, valid_out, error, AddrB);
        end
        do_reset();
        #1;
        checks++;
        if (error !== 1'b0 || count !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_clears_error: error=%b count=%0d empty=%b, expected 0 0 1", error, count, empty);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        push_seq(4'h1, 8, 0, 0);
        set_in(1'b1, 4'h9, 1'b1);
        checks++;
        if (rwA !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop_rwA: rwA=%b, expected 1", rwA);
        end
        tick();
        set_in(1'b0, '0, 1'b0);
        checks++;
        if (count !== 4'd8 || valid_out !== 1'b1 || data_out !== 4'h1 || error !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop: count=%0d valid_out=%b data_out=%h error=%b, expected 8 1 1 0",
                     count, valid_out, data_out, error);
        end
        pop_seq(4'h2, 8);
    endtask

    task automatic test_wrap();
        do_reset();
        push_seq(4'h1, 5, 0, 0);
        pop_seq(4'h1, 5);
        push_seq(4'hA, 6, 5, 0);
        checks++;
        if (AddrA !== 3'd3 || AddrB !== 3'd5) begin
            errors++;
            $display("FAIL wrap_ptrs: AddrA=%0d AddrB=%0d, expected 3 5", AddrA, AddrB);
        end
        pop_seq(4'hA, 6);
        checks++;
        if (empty !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: empty=%b error=%b, expected 1 0", empty, error);
        end
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_full_push_pop();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
